universal_register_n: RTL

- Parametrised successor to the team's 8-bit clear/enable data register.
- Generalised to WIDTH bits with an active-low enable and synchronous clear.
- Adds a mode select: hold, load, shift, rotate, arithmetic shift and increment.
- Adds a multi-cycle burst-shift engine with busy/done handshake and a registered serial-out bit. Used as a datapath operand register and as a serialiser feeding bit-serial experiment blocks.

---
 rtl/universal_register_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/universal_register_n.sv
// -----------------------------------------------------------------------------
// universal_register_n
//
// WIDTH-bit operand/serialiser register. It supports single-step operations
// (hold, load, shift, rotate, arithmetic shift, increment) and a multi-cycle
// burst-shift engine with a busy/done handshake.
//
// Ports
//   clk     in   1      rising-edge clock
//   clr     in   1      synchronous active-high clear, highest priority
//   en_     in   1      active-low enable (1 = freeze everything except clr)
//   D       in   WIDTH  parallel load data
//   mode    in   3      operation select
//   sin     in   1      serial input for SHL/SHR
//   start   in   1      request a burst of `amount` steps of `mode`
//   amount  in   AMT_W  burst step count
//   Z       out  WIDTH  register contents
//   sout    out  1      last bit shifted/rotated out (registered)
//   busy    out  1      burst in progress
//   done    out  1      one-cycle pulse at burst completion
//
// Mode encoding
//   000 HOLD | 001 LOAD | 010 SHL | 011 SHR | 100 ROL | 101 ROR | 110 ASR | 111 INC
//
// FSM states
//   state | meaning
//   IDLE  | single-step per enabled edge; a start with a shift-class mode is accepted here
//   RUN   | burst active; one step of the latched mode per enabled edge, cnt counts down
// -----------------------------------------------------------------------------
module universal_register_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en_,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] Z,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_INC  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bmode_q, bmode_d;

  logic [2:0]       op;
  logic [WIDTH-1:0] step_z;
  logic             step_sout;
  logic             burst_ok;

  // While a burst runs the latched mode drives the datapath; the live mode
  // input is ignored.
  assign op = (state_q == RUN) ? bmode_q : mode;

  // Only the shift/rotate class (010..110) may be run as a burst.
  assign burst_ok = (mode >= M_SHL) && (mode <= M_ASR);

  // One step of the selected operation, computed from the current contents.
  always_comb begin
    step_z    = z_q;
    step_sout = sout_q;
    case (op)
      M_HOLD: begin
        step_z = z_q;
      end
      M_LOAD: begin
        step_z = D;
      end
      M_SHL: begin
        step_z    = {z_q[WIDTH-2:0], sin};
        step_sout = z_q[WIDTH-1];
      end
      M_SHR: begin
        step_z    = {sin, z_q[WIDTH-1:1]};
        step_sout = z_q[0];
      end
      M_ROL: begin
        step_z    = {z_q[WIDTH-2:0], z_q[WIDTH-1]};
        step_sout = z_q[WIDTH-1];
      end
      M_ROR: begin
        step_z    = {z_q[0], z_q[WIDTH-1:1]};
        step_sout = z_q[0];
      end
      M_ASR: begin
        step_z    = {z_q[WIDTH-1], z_q[WIDTH-1:1]};
        step_sout = z_q[0];
      end
      M_INC: begin
        step_z = z_q + WIDTH'(1);
      end
      default: begin
        step_z = z_q;
      end
    endcase
  end

  // Next-state logic. done is a pulse, so it defaults low on every edge.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;

    if (!en_) begin
      case (state_q)
        IDLE: begin
          if (start && burst_ok) begin
            // The accept edge only latches the burst; no step happens here.
            bmode_d = mode;
            if (amount == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = amount;
              busy_d  = 1'b1;
              state_d = RUN;
            end
          end else begin
            z_d    = step_z;
            sout_d = step_sout;
          end
        end
        RUN: begin
          z_d    = step_z;
          sout_d = step_sout;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      z_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bmode_q <= M_HOLD;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
    end
  end

  assign Z    = z_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
